// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Sequences the PLL reset, qualifies PLL lock through a
//               synchronizer and settle window, gates the downstream clock
//               enable while lock is stable, and retries failed bring-up
//               attempts with a bounded budget before parking in sticky FAIL.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_lock,
    input  logic       fail_clr,
    output logic       pllrst,
    output logic       clken,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    // Terminal timer values: the timer starts at zero on state entry, so the
    // last cycle of an N-cycle interval is N-1.
    localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       c_MAX_RETRY   = 4'(MAX_RETRY);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_timer;
    logic [3:0]       r_retry_cnt;
    logic [3:0]       w_next_retry;
    logic             r_lock_meta;
    logic             r_lock_sync;
    logic             w_retry;

    // Two-flop synchronizer for the asynchronous PLL lock pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_sync <= r_lock_meta;
        end
    end

    // State, timer and retry-count registers; timer restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_retry_cnt <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_retry_cnt <= w_next_retry;
            if (w_next_state != r_state) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Next-state decode: enable drop wins, then fail_clr, then lock/timer events.
    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry_cnt;
        w_retry      = 1'b0;

        if ((r_state != S_IDLE) && (r_state != S_FAIL) && !enable) begin
            w_next_state = S_IDLE;
            w_next_retry = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        w_next_state = S_RESET;
                    end
                end
                S_RESET: begin
                    if (r_timer == c_RST_LAST) begin
                        w_next_state = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_sync) begin
                        w_next_state = S_SETTLE;
                    end else if (r_timer == c_TIMEOUT) begin
                        w_retry = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!r_lock_sync) begin
                        w_retry = 1'b1;
                    end else if (r_timer == c_SETTLE_LAST) begin
                        w_next_state = S_RUN;
                        w_next_retry = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!r_lock_sync) begin
                        w_retry = 1'b1;
                    end
                end
                S_FAIL: begin
                    if (fail_clr) begin
                        w_next_state = S_IDLE;
                        w_next_retry = 4'd0;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_retry = 4'd0;
                end
            endcase

            // A failed attempt either consumes budget or, once exhausted, parks.
            // The count only advances below the limit, so it can never wrap.
            if (w_retry) begin
                if (r_retry_cnt >= c_MAX_RETRY) begin
                    w_next_state = S_FAIL;
                end else begin
                    w_next_state = S_RESET;
                    w_next_retry = r_retry_cnt + 4'd1;
                end
            end
        end
    end

    // Outputs decode straight from the registered state so clken drops on the
    // same edge the FSM leaves RUN.
    assign pllrst    = (r_state == S_IDLE) || (r_state == S_RESET) || (r_state == S_FAIL);
    assign clken     = (r_state == S_RUN);
    assign locked    = (r_state == S_RUN);
    assign fail      = (r_state == S_FAIL);
    assign retry_cnt = r_retry_cnt;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_sequencer
// Description : Scoreboard bench for pll_lock_sequencer. A behavioural model
//               predicts the outputs after every clock edge; a monitor pops
//               and compares them half a cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int P_RST    = 4;
    localparam int P_TO     = 32;
    localparam int P_SETTLE = 8;
    localparam int P_MAXR   = 2;

    localparam int M_IDLE   = 0;
    localparam int M_RESET  = 1;
    localparam int M_WAIT   = 2;
    localparam int M_SETTLE = 3;
    localparam int M_RUN    = 4;
    localparam int M_FAIL   = 5;

    typedef struct packed {
        logic [2:0] st;
        logic       pllrst;
        logic       clken;
        logic       locked;
        logic       fail;
        logic [3:0] rc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       pll_lock;
    logic       fail_clr;
    logic       pllrst;
    logic       clken;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    // Model state: phase, cycles spent in it, failed attempts, lock pipeline.
    int   m_st   = M_IDLE;
    int   m_age  = 0;
    int   m_rc   = 0;
    bit   m_pipe[$];

    pll_lock_sequencer #(
        .RST_CYCLES   (P_RST),
        .LOCK_TIMEOUT (P_TO),
        .SETTLE_CYCLES(P_SETTLE),
        .MAX_RETRY    (P_MAXR),
        .CNT_W        (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .pll_lock (pll_lock),
        .fail_clr (fail_clr),
        .pllrst   (pllrst),
        .clken    (clken),
        .locked   (locked),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A failed attempt: spend budget or park.
    function automatic void model_fail_attempt(output int nst);
        if (m_rc == P_MAXR) begin
            nst = M_FAIL;
        end else begin
            m_rc = m_rc + 1;
            nst  = M_RESET;
        end
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    function automatic void model_edge();
        int nst;
        bit ls;
        if (rst) begin
            m_st  = M_IDLE;
            m_age = 0;
            m_rc  = 0;
            m_pipe = '{1'b0, 1'b0};
            return;
        end
        ls  = m_pipe[0];
        nst = m_st;
        if (m_st != M_IDLE && m_st != M_FAIL && !enable) begin
            nst  = M_IDLE;
            m_rc = 0;
        end else if (m_st == M_IDLE) begin
            if (enable) nst = M_RESET;
        end else if (m_st == M_RESET) begin
            if (m_age + 1 >= P_RST) nst = M_WAIT;
        end else if (m_st == M_WAIT) begin
            if (ls) nst = M_SETTLE;
            else if (m_age + 1 >= P_TO) model_fail_attempt(nst);
        end else if (m_st == M_SETTLE) begin
            if (!ls) model_fail_attempt(nst);
            else if (m_age + 1 >= P_SETTLE) begin
                nst  = M_RUN;
                m_rc = 0;
            end
        end else if (m_st == M_RUN) begin
            if (!ls) model_fail_attempt(nst);
        end else begin
            if (fail_clr) begin
                nst  = M_IDLE;
                m_rc = 0;
            end
        end
        m_age = (nst != m_st) ? 0 : m_age + 1;
        m_st  = nst;
        void'(m_pipe.pop_front());
        m_pipe.push_back(pll_lock);
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.st     = 3'(m_st);
        e.pllrst = (m_st == M_IDLE) || (m_st == M_RESET) || (m_st == M_FAIL);
        e.clken  = (m_st == M_RUN);
        e.locked = (m_st == M_RUN);
        e.fail   = (m_st == M_FAIL);
        e.rc     = 4'(m_rc);
        return e;
    endfunction

    // One clock: edge, model update, push expectation, then settle past the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_outputs());
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (m_st != target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (m_st != target) begin
            errors++;
            $display("FAIL %s: model state %0d, required %0d within %0d cycles", tag, m_st, target, budget);
        end
    endtask

    // Monitor: compare every presented output sample against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (state !== e.st || pllrst !== e.pllrst || clken !== e.clken ||
                    locked !== e.locked || fail !== e.fail || retry_cnt !== e.rc) begin
                    errors++;
                    $display("FAIL outputs @%0t: got st=%0d rst=%b ck=%b lk=%b f=%b rc=%0d, want st=%0d rst=%b ck=%b lk=%b f=%b rc=%0d",
                             $time, state, pllrst, clken, locked, fail, retry_cnt,
                             e.st, e.pllrst, e.clken, e.locked, e.fail, e.rc);
                end
            end
        end
    end

    initial begin : stimulus
        int hold;
        rst = 1'b1; enable = 1'b0; pll_lock = 1'b0; fail_clr = 1'b0;
        m_pipe = '{1'b0, 1'b0};
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Nominal bring-up.
        enable = 1'b1;
        run_until(M_WAIT, 20, "bringup_wait");
        cyc(10);
        pll_lock = 1'b1;
        run_until(M_RUN, 30, "bringup_run");
        cyc(5);

        // Lock timeout to FAIL, enable ignored in FAIL, then clear.
        enable = 1'b0; pll_lock = 1'b0;
        cyc(2);
        enable = 1'b1;
        run_until(M_FAIL, 200, "timeout_fail");
        cyc(3);
        enable = 1'b0;
        cyc(4);
        fail_clr = 1'b1;
        step();
        fail_clr = 1'b0;
        cyc(3);

        // Settle glitch, then stable lock to RUN.
        enable = 1'b1;
        run_until(M_WAIT, 20, "glitch_wait");
        pll_lock = 1'b1;
        run_until(M_SETTLE, 10, "glitch_settle");
        cyc(2);
        pll_lock = 1'b0;
        cyc(3);
        pll_lock = 1'b1;
        run_until(M_RUN, 100, "glitch_run");
        cyc(4);

        // Lock loss in RUN and re-lock.
        pll_lock = 1'b0;
        cyc(6);
        pll_lock = 1'b1;
        run_until(M_RUN, 100, "relock_run");
        cyc(3);

        // enable drop in RUN and in WAIT_LOCK.
        enable = 1'b0;
        cyc(3);
        pll_lock = 1'b0;
        enable = 1'b1;
        run_until(M_WAIT, 20, "drop_wait");
        cyc(5);
        enable = 1'b0;
        cyc(3);

        // rst during SETTLE, then IDLE ignores lock and fail_clr.
        enable = 1'b1; pll_lock = 1'b1;
        run_until(M_SETTLE, 30, "rst_settle");
        cyc(2);
        rst = 1'b1;
        step();
        rst = 1'b0; enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pll_lock = i[0];
            fail_clr = i[1];
            step();
        end
        fail_clr = 1'b0;

        // Randomized traffic.
        hold = 0;
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            if (hold == 0) begin
                pll_lock = ~pll_lock;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 60);
            end else begin
                hold--;
            end
            fail_clr = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0; fail_clr = 1'b0;
        cyc(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Controller that sequences the primary PLL reset, waits for and qualifies PLL lock, and gates the downstream clock enable only while lock is stable. It detects lock timeout and loss of lock, retries with a bounded budget, and parks in a sticky FAIL state when retries are exhausted. It sits in the reference-clock domain, between the board-level enable and the PLL's reset and lock pins, and feeds the clock-enable of the counters clocked by the PLL.

Parameters:
RST_CYCLES, 16, cycles pllrst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 1024, max cycles in WAIT_LOCK before an attempt counts as failed (>=1)
SETTLE_CYCLES, 64, consecutive synchronized-lock cycles required before RUN (>=1)
MAX_RETRY, 3, failed attempts tolerated before FAIL (0..15)
CNT_W, 12, timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)

Ports:
clk  in  1  reference clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  level request to bring up and keep the PLL running
pll_lock  in  1  PLL lock output, asynchronous to clk
fail_clr  in  1  single-cycle pulse; clears FAIL
pllrst  out  1  PLL reset, active-high
clken  out  1  qualified clock enable for PLL-clocked logic
locked  out  1  high while in RUN
fail  out  1  sticky failure flag
retry_cnt  out  4  failed attempts since the last IDLE or RUN entry
state  out  3  IDLE=0, RESET=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAIL=5

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pllrst=1, clken=0, locked=0, fail=0, retry_cnt=0, timer=0, both sync flops=0.
- pll_lock passes through a 2-flop synchronizer to give lock_s (2-cycle latency). Only lock_s is used.
- All outputs are registered and decoded from the registered state:
  - pllrst=1 in IDLE, RESET, FAIL.
  - clken=locked=1 only in RUN.
  - fail=1 only in FAIL.
- Timer clears on every state change and increments otherwise.
- IDLE: enable=1 -> RESET.
- RESET: after RST_CYCLES cycles in RESET -> WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1 -> SETTLE.
  - timer reaches LOCK_TIMEOUT-1 with lock_s=0 -> retry path.
- SETTLE:
  - lock_s=0 at any point -> retry path.
  - SETTLE_CYCLES consecutive cycles with lock_s=1 -> RUN; retry_cnt cleared on RUN entry.
- RUN: lock_s=0 -> retry path. clken falls at most 3 clk edges after pll_lock falls.
- Retry path:
  - retry_cnt==MAX_RETRY -> FAIL.
  - Otherwise retry_cnt+1 -> RESET.
  - retry_cnt saturates and never wraps.
- FAIL:
  - Ignores enable and pll_lock.
  - fail_clr=1 -> IDLE, retry_cnt=0.
- enable=0 in RESET, WAIT_LOCK, SETTLE or RUN -> IDLE next edge, with priority over all other transitions; retry_cnt=0.
- Priority, highest first: rst, enable=0 (non-FAIL states only), fail_clr (FAIL only), lock and timer events.
- fail_clr outside FAIL has no effect.
- rst mid-operation aborts immediately to the reset values; no partial attempt is preserved.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, MAX_RETRY=2.
1. Nominal bring-up: rst, then enable=1; pll_lock rises 10 cycles after pllrst falls -> pllrst high exactly 4 cycles in RESET; state goes 1->2->3->4; clken=locked=1 after 8 settle cycles; retry_cnt=0.
2. Lock timeout: pll_lock held 0 -> three attempts of 32 WAIT_LOCK cycles each; retry_cnt 0->1->2; then FAIL with fail=1, pllrst=1. fail_clr pulse -> IDLE, fail=0, retry_cnt=0.
3. Settle glitch: pll_lock high for 5 cycles, then low for 3, during SETTLE -> retry path, retry_cnt=1, RESET re-entered with pllrst high 4 cycles. A stable lock afterwards reaches RUN and clears retry_cnt.
4. Lock loss in RUN: drop pll_lock -> clken falls within 3 edges, retry_cnt=1, re-lock reaches RUN.
5. enable=0 while in WAIT_LOCK and while in RUN -> IDLE next edge, pllrst=1, clken=0, retry_cnt=0. enable=0 while in FAIL -> stays in FAIL.
6. rst asserted in SETTLE with pll_lock=1 -> next edge gives all reset values, state=IDLE; pll_lock toggling and fail_clr pulses in IDLE have no effect.
